// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter
// Iterative AES inverse cipher (AES-128/192/256), one decryption round per clock.
// Round keys arrive on a flat bus from the key schedule and are not latched here,
// so they must stay stable while a block is in flight.
// Optional feature: define AES_DEC_ABORT_EN to add an `abort` input that drops
// the block in flight and returns to IDLE without producing an output.
module aes_inv_cipher_iter #(
    parameter  int KEY_BITS = 128,
    localparam int NR       = KEY_BITS / 32 + 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [128*(NR+1)-1:0]   round_keys_flat,
    input  logic [127:0]            cipher_text,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [127:0]            plain_text,
    output logic                    out_valid,
    input  logic                    out_ready,
`ifdef AES_DEC_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    busy
);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_inv_cipher_iter: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } fsm_t;

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo 0x11b.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm09(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] gm0b(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] gm0d(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] gm0e(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    // Byte k sits at bits [127-8k -: 8] and maps to row k%4, column k/4.
    // Row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (row + 4 * c) -: 8] = s[127 - 8 * (row + 4 * ((c - row + 4) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            r[127 - 32 * c -: 8] = gm0e(a0) ^ gm0b(a1) ^ gm0d(a2) ^ gm09(a3);
            r[119 - 32 * c -: 8] = gm09(a0) ^ gm0e(a1) ^ gm0b(a2) ^ gm0d(a3);
            r[111 - 32 * c -: 8] = gm0d(a0) ^ gm09(a1) ^ gm0e(a2) ^ gm0b(a3);
            r[103 - 32 * c -: 8] = gm0b(a0) ^ gm0d(a1) ^ gm09(a2) ^ gm0e(a3);
        end
        return r;
    endfunction

    fsm_t         fsm;
    logic [127:0] aes_state;
    logic [3:0]   round_q;
    logic [127:0] rk_cur;
    logic [127:0] t_key;
    logic [127:0] t_mix;

    assign rk_cur = round_keys_flat[128 * int'(round_q) +: 128];
    assign t_key  = inv_sub_bytes(inv_shift_rows(aes_state)) ^ rk_cur;
    assign t_mix  = inv_mix_columns(t_key);

    // in_ready depends only on the state register (and reset), never on the handshakes.
    assign in_ready = (fsm == S_IDLE) && rst_n;
    assign busy     = (fsm != S_IDLE);

    // Round-loop FSM: accept with initial AddRoundKey, iterate rounds, hold result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm        <= S_IDLE;
            aes_state  <= '0;
            round_q    <= '0;
            plain_text <= '0;
            out_valid  <= 1'b0;
        end
`ifdef AES_DEC_ABORT_EN
        else if (abort && fsm != S_IDLE) begin
            fsm       <= S_IDLE;
            out_valid <= 1'b0;
        end
`endif
        else begin
            case (fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        aes_state <= cipher_text ^ round_keys_flat[128 * NR +: 128];
                        round_q   <= 4'(NR - 1);
                        fsm       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (round_q != 4'd0) begin
                        aes_state <= t_mix;
                        round_q   <= round_q - 4'd1;
                    end else begin
                        // Final round skips InvMixColumns.
                        plain_text <= t_key;
                        out_valid  <= 1'b1;
                        fsm        <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= S_IDLE;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter
// Directed bench for aes_inv_cipher_iter with FIPS-197 vectors for all key sizes.
// Round keys are produced by a key-expansion model whose S-box is derived
// arithmetically (GF inverse + affine map). Define AES_DEC_ABORT_EN to exercise abort.
module tb_aes_inv_cipher_iter;

    localparam logic [127:0] PT_EXP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic out_ready;
`ifdef AES_DEC_ABORT_EN
    logic abort;
`endif

    logic [128*11-1:0] rk128;
    logic [128*13-1:0] rk192;
    logic [128*15-1:0] rk256;
    logic [127:0] ct128, ct192, ct256, pt128, pt192, pt256;
    logic iv128, iv192, iv256, ir128, ir192, ir256;
    logic ov128, ov192, ov256, bz128, bz192, bz256;

    int n_checks = 0;
    int n_errors = 0;

    aes_inv_cipher_iter #(.KEY_BITS(128)) u128 (
        .clk(clk), .rst_n(rst_n), .round_keys_flat(rk128), .cipher_text(ct128),
        .in_valid(iv128), .in_ready(ir128), .plain_text(pt128), .out_valid(ov128),
        .out_ready(out_ready),
`ifdef AES_DEC_ABORT_EN
        .abort(abort),
`endif
        .busy(bz128)
    );

    aes_inv_cipher_iter #(.KEY_BITS(192)) u192 (
        .clk(clk), .rst_n(rst_n), .round_keys_flat(rk192), .cipher_text(ct192),
        .in_valid(iv192), .in_ready(ir192), .plain_text(pt192), .out_valid(ov192),
        .out_ready(out_ready),
`ifdef AES_DEC_ABORT_EN
        .abort(1'b0),
`endif
        .busy(bz192)
    );

    aes_inv_cipher_iter #(.KEY_BITS(256)) u256 (
        .clk(clk), .rst_n(rst_n), .round_keys_flat(rk256), .cipher_text(ct256),
        .in_valid(iv256), .in_ready(ir256), .plain_text(pt256), .out_valid(ov256),
        .out_ready(out_ready),
`ifdef AES_DEC_ABORT_EN
        .abort(1'b0),
`endif
        .busy(bz256)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference key schedule ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15 - n -: 8];
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        inv  = 8'h01;
        base = x;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_model(w[31:24]), sbox_model(w[23:16]), sbox_model(w[15:8]), sbox_model(w[7:0])};
    endfunction

    // key is left-aligned in 256 bits; round key r lands at [128r +: 128].
    function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [0:59];
        logic [31:0]   tmp;
        logic [7:0]    rcon;
        logic [1919:0] flat;
        rcon = 8'h01;
        flat = '0;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            tmp = w[i - 1];
            if (i % nk == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i - nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) flat[128 * r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return flat;
    endfunction

    // ---------------- per-instance accessors ----------------
    function automatic logic get_ov(input int ks);
        case (ks)
            128:     return ov128;
            192:     return ov192;
            default: return ov256;
        endcase
    endfunction

    function automatic logic get_ir(input int ks);
        case (ks)
            128:     return ir128;
            192:     return ir192;
            default: return ir256;
        endcase
    endfunction

    function automatic logic get_busy(input int ks);
        case (ks)
            128:     return bz128;
            192:     return bz192;
            default: return bz256;
        endcase
    endfunction

    function automatic logic [127:0] get_pt(input int ks);
        case (ks)
            128:     return pt128;
            192:     return pt192;
            default: return pt256;
        endcase
    endfunction

    task automatic drive(input int ks, input logic v, input logic [127:0] ct);
        case (ks)
            128:     begin iv128 = v; ct128 = ct; end
            192:     begin iv192 = v; ct192 = ct; end
            default: begin iv256 = v; ct256 = ct; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one block from IDLE and wait (bounded) for out_valid.
    task automatic run_block(input int ks, input logic [127:0] ct, input string tag);
        int lat;
        int nr;
        nr = ks / 32 + 6;
        drive(ks, 1'b1, ct);
        tick();
        drive(ks, 1'b0, ct);
        check({tag, " busy after accept"}, 128'(get_busy(ks)), 128'(1'b1));
        check({tag, " in_ready after accept"}, 128'(get_ir(ks)), 128'(1'b0));
        lat = 0;
        while (!get_ov(ks) && lat < 64) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(nr));
        check({tag, " plain_text"}, get_pt(ks), PT_EXP);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1919:0] kx;
        int acc_t [0:3];
        int acc_cnt;
        int out_cnt;
        int n;
        logic acc;
        logic seen_ov;

        rst_n = 1'b0;
        out_ready = 1'b1;
        iv128 = 1'b0; iv192 = 1'b0; iv256 = 1'b0;
        ct128 = CT128; ct192 = CT192; ct256 = CT256;
`ifdef AES_DEC_ABORT_EN
        abort = 1'b0;
`endif
        kx = expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
        rk128 = kx[128*11-1:0];
        kx = expand_key({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6, 12);
        rk192 = kx[128*13-1:0];
        kx = expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        rk256 = kx;

        // reset state
        tick();
        tick();
        check("reset out_valid", 128'(ov128), 128'(1'b0));
        check("reset plain_text", pt128, 128'h0);
        check("reset busy", 128'(bz128), 128'(1'b0));
        check("reset in_ready low", 128'(ir128), 128'(1'b0));
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", 128'(ir128), 128'(1'b1));

        // AES-128 vector, then handshake and hold of plain_text
        run_block(128, CT128, "aes128");
        tick();
        check("aes128 out_valid after handshake", 128'(ov128), 128'(1'b0));
        check("aes128 busy after handshake", 128'(bz128), 128'(1'b0));
        check("aes128 pt held after handshake", pt128, PT_EXP);

        // backpressure with in_valid held high
        out_ready = 1'b0;
        run_block(128, CT128, "bp first");
        drive(128, 1'b1, CT128);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp out_valid held", 128'(ov128), 128'(1'b1));
            check("bp plain_text held", pt128, PT_EXP);
            check("bp in_ready low", 128'(ir128), 128'(1'b0));
        end
        out_ready = 1'b1;
        tick();
        check("bp out_valid dropped", 128'(ov128), 128'(1'b0));
        check("bp in_ready in idle", 128'(ir128), 128'(1'b1));
        tick();
        drive(128, 1'b0, CT128);
        check("bp second accepted busy", 128'(bz128), 128'(1'b1));
        n = 0;
        while (!ov128 && n < 64) begin
            tick();
            n++;
        end
        check("bp second latency", 128'(n), 128'(10));
        check("bp second plain_text", pt128, PT_EXP);
        tick();

        // back-to-back, 4 blocks
        acc_cnt = 0;
        out_cnt = 0;
        for (int i = 0; i < 4; i++) acc_t[i] = 0;
        n = 0;
        drive(128, 1'b1, CT128);
        for (int k = 0; k < 200 && out_cnt < 4; k++) begin
            acc = iv128 && ir128;
            if (ov128 && out_ready) begin
                check("b2b plain_text", pt128, PT_EXP);
                out_cnt++;
            end
            tick();
            n++;
            if (acc && acc_cnt < 4) begin
                acc_t[acc_cnt] = n;
                acc_cnt++;
                if (acc_cnt == 4) iv128 = 1'b0;
            end
        end
        iv128 = 1'b0;
        check("b2b accept count", 128'(acc_cnt), 128'(4));
        check("b2b output count", 128'(out_cnt), 128'(4));
        for (int i = 1; i < 4; i++) check("b2b issue interval", 128'(acc_t[i] - acc_t[i-1]), 128'(12));

        // reset at round 5
        drive(128, 1'b1, CT128);
        tick();
        drive(128, 1'b0, CT128);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        check("midreset out_valid", 128'(ov128), 128'(1'b0));
        check("midreset plain_text", pt128, 128'h0);
        check("midreset busy", 128'(bz128), 128'(1'b0));
        rst_n = 1'b1;
        #1;
        check("midreset in_ready", 128'(ir128), 128'(1'b1));
        run_block(128, CT128, "after reset");
        tick();

        // AES-192 and AES-256
        run_block(192, CT192, "aes192");
        tick();
        run_block(256, CT256, "aes256");
        tick();

`ifdef AES_DEC_ABORT_EN
        // abort at round 3
        drive(128, 1'b1, CT128);
        tick();
        drive(128, 1'b0, CT128);
        repeat (6) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", 128'(bz128), 128'(1'b0));
        check("abort in_ready", 128'(ir128), 128'(1'b1));
        check("abort out_valid", 128'(ov128), 128'(1'b0));
        check("abort pt held", pt128, PT_EXP);
        seen_ov = 1'b0;
        repeat (12) begin
            tick();
            if (ov128) seen_ov = 1'b1;
        end
        check("abort no out_valid pulse", 128'(seen_ov), 128'(1'b0));
        // abort in IDLE does not block an accept
        abort = 1'b1;
        drive(128, 1'b1, CT128);
        tick();
        abort = 1'b0;
        drive(128, 1'b0, CT128);
        check("abort idle accept", 128'(bz128), 128'(1'b1));
        n = 0;
        while (!ov128 && n < 64) begin
            tick();
            n++;
        end
        check("abort idle plain_text", pt128, PT_EXP);
        tick();
`else
        seen_ov = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative, parameterised AES inverse cipher with a valid/ready handshake. It runs one decryption round per clock for AES-128, AES-192 or AES-256 and takes precomputed round keys from the key-expansion block's flat bus. It implements the full FIPS-197 inverse cipher: InvShiftRows, InvSubBytes, AddRoundKey and InvMixColumns. It sits between the key schedule and the system datapath, and supersedes the XOR-only decrypt core.

## Interface
- `KEY_BITS`, default 128: key size; legal values are 128, 192 and 256, and any other value is a compile-time error.
- `NR`, derived (`KEY_BITS/32 + 6`): round count, giving 10, 12 or 14.
- `clk` in 1: the only clock; all logic is on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `round_keys_flat` in `128*(NR+1)`: round key i is at bits `[128*i+127 : 128*i]`. Key 0 is the first 128 key bits.
- `cipher_text` in 128: input block. Byte 0 is bits [127:120]; bytes map to the state column-major per FIPS-197.
- `in_valid` in 1: `cipher_text` is valid.
- `in_ready` out 1: the block accepts input this cycle.
- `plain_text` out 128: result block, same byte order as `cipher_text`.
- `out_valid` out 1: `plain_text` is valid.
- `out_ready` in 1: the consumer accepts the result.
- `busy` out 1: high in ROUND and DONE.

## Operation
- FSM states are IDLE, ROUND and DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: `state <= cipher_text ^ rk[NR]`, `round <= NR-1`, go to ROUND.
- **ROUND**, one round per cycle:
  - `t = InvSubBytes(InvShiftRows(state)) ^ rk[round]`.
  - If `round != 0`: `state <= InvMixColumns(t)`, `round <= round-1`.
  - If `round == 0`: `plain_text <= t`, `out_valid <= 1`, go to DONE. No InvMixColumns on the final round.
- **DONE**
  - `out_valid` and `plain_text` are held stable until `out_ready`=1.
  - On that cycle: `out_valid <= 0`, go to IDLE.
  - `plain_text` keeps its value after the handshake.
- `in_ready` = (fsm==IDLE) && `rst_n`. It is combinational from the state register only and never depends on `out_ready` or `in_valid`.
- InvSubBytes uses a 256-entry combinational inverse S-box, 16 instances.
- InvMixColumns coefficients are {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11b.
- The round counter is 4 bits wide. It decrements from NR-1 to 0 and never wraps, because the ROUND state exits at 0.
- `round_keys_flat` must stay stable from the accept cycle until `out_valid` rises. It is not latched internally.
- `in_valid` while busy is ignored. The block does not buffer or queue input.

## Timing
- Reset values when `rst_n`=0 at an edge:
  - fsm=IDLE, `out_valid`=0, `plain_text`=0, `busy`=0, internal state=0, round=0.
  - `in_ready` is 0 while `rst_n` is low.
- Reset mid-operation (ROUND or DONE) discards the block. The next edge yields the reset values, with no partial output.
- Latency: accept at edge E; `out_valid` is high after edge E+NR, i.e. 10, 12 or 14 cycles.
- `busy` is high from E+1 until the edge that completes the output handshake.
- Minimum issue interval is NR+2 cycles when `out_ready` is held at 1:
  - NR cycles in ROUND, plus 1 cycle in DONE, plus 1 cycle in IDLE to accept.
- `out_ready`=1 and `in_valid`=1 in the same DONE cycle: only the output handshake completes. The new input is accepted on the following cycle, in IDLE.

## Configuration
- `AES_DEC_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort`=1 in ROUND or DONE: the next edge goes to IDLE, `out_valid`=0, and `plain_text` keeps its previous value.
  - `abort` in IDLE has no effect.
  - `rst_n`=0 has priority over `abort`.
- `AES_DEC_ABORT_EN` not defined: the port is absent and the FSM has no abort path.

## Test plan
- **AES-128 vector**
  - Stimulus: `KEY_BITS`=128, key 000102030405060708090a0b0c0d0e0f, round keys from `aes_key_expansion`, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: pt 00112233445566778899aabbccddeeff, with `out_valid` rising exactly 10 cycles after accept.
- **AES-192 and AES-256 vectors**
  - Stimulus: key 000102…17 with ct dda97ca4864cdfe06eaf70a0ec0d7191, and key 000102…1f with ct 8ea2b7ca516745bfeafc49904b496089. Round keys come from the bench model.
  - Response: pt 00112233445566778899aabbccddeeff for both, with latency 12 and 14 respectively.
- **Backpressure**
  - Stimulus: hold `out_ready`=0 for 5 cycles after `out_valid`, and drive `in_valid`=1 throughout.
  - Response: `plain_text` and `out_valid` are stable, `in_ready`=0, and the second block is accepted exactly one cycle after the handshake.
- **Back-to-back**
  - Stimulus: 4 AES-128 blocks with `out_ready`=1 and `in_valid`=1 continuously.
  - Response: accepts every 12 cycles and all outputs are correct.
- **Reset mid-round**
  - Stimulus: `rst_n`=0 for 1 cycle at round 5.
  - Response: next cycle `out_valid`=0, `plain_text`=0, `in_ready`=1. A fresh block then decrypts correctly.
- **Abort** (`AES_DEC_ABORT_EN` defined)
  - Stimulus: assert `abort` at round 3.
  - Response: IDLE on the next cycle, no `out_valid` pulse, and `plain_text` holds its prior result.
